mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with read, write and
// compare-and-swap (CAS) operations and a programmable response latency.
// Words that were never written since reset read back as EMPTY_KEY; this is
// tracked with one valid bit per word so the data array itself needs no reset.
// Optional feature: define MEM_RESPONDER_STALL_EN to add pseudo-random request
// back-pressure driven by an 8-bit Fibonacci LFSR.
module mem_responder #(
    parameter int                 DATA_W      = 32,
    parameter int                 DEPTH       = 256,
    parameter int                 RSP_LATENCY = 2,
    parameter logic [DATA_W-1:0]  EMPTY_KEY   = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic              addr_err_o
);

    localparam int SHIFT = $clog2(DATA_W / 8);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [3:0]          cnt_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic                err_reg;
    logic [DEPTH-1:0]    valid_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic [DATA_W-1:0]   word_idx;
    logic                in_range;
    logic [AW-1:0]       word_addr;
    logic [DATA_W-1:0]   cur_word;
    logic                do_store;
    logic                mem_we;
    logic [DATA_W-1:0]   rsp_value;

    // Address decode: byte address to word index, range check against DEPTH
    assign word_idx  = mem_req_addr_i >> SHIFT;
    assign in_range  = (word_idx < DATA_W'(DEPTH));
    assign word_addr = word_idx[AW-1:0];
    assign cur_word  = valid_reg[word_addr] ? mem[word_addr] : EMPTY_KEY;
    assign accept    = mem_req_val_i && mem_req_rdy_o;
    assign mem_we    = accept && do_store;

    // Operation decode: decide whether the word is updated and what the response carries
    always_comb begin
        do_store  = 1'b0;
        rsp_value = '0;
        if (in_range) begin
            if (mem_req_is_cas_i) begin
                if (cur_word == EMPTY_KEY) begin
                    do_store = 1'b1;
                end else begin
                    rsp_value = DATA_W'(1);
                end
            end else if (mem_req_is_write_i) begin
                do_store = 1'b1;
            end else begin
                rsp_value = cur_word;
            end
        end
    end

    // Data array write port; compare and update happen on the same acceptance edge
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[word_addr] <= mem_req_data_i;
        end
    end

    // Per-word written flags; cleared by reset so every word reads as EMPTY_KEY
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        // Set the flag of the word being stored to
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_reg[gi] <= 1'b0;
            end else if (mem_we && (word_addr == AW'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end
        end
    end

    // Capture response data, load/decrement latency counter, latch sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data_reg <= '0;
            cnt_reg      <= 4'd0;
            err_reg      <= 1'b0;
        end else if (accept) begin
            rsp_data_reg <= rsp_value;
            cnt_reg      <= 4'(RSP_LATENCY - 1);
            if (!in_range) begin
                err_reg <= 1'b1;
            end
        end else if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; BUSY leaves when the counter is about to reach zero
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (RSP_LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (mem_rsp_rdy_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MEM_RESPONDER_STALL_EN
    logic [7:0] lfsr_reg;

    // Free-running LFSR (taps 8,6,5,4) used to inject request back-pressure
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_reg <= 8'hA5;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    // FSM outputs; ready additionally masked by the LFSR
    always_comb begin
        mem_req_rdy_o  = (state_reg == IDLE) && !lfsr_reg[0];
        mem_rsp_val_o  = (state_reg == RESP);
        mem_rsp_data_o = (state_reg == RESP) ? rsp_data_reg : '0;
    end
`else
    // FSM outputs; response data forced to zero outside RESP
    always_comb begin
        mem_req_rdy_o  = (state_reg == IDLE);
        mem_rsp_val_o  = (state_reg == RESP);
        mem_rsp_data_o = (state_reg == RESP) ? rsp_data_reg : '0;
    end
`endif

    assign addr_err_o = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: read/write/CAS, latency, back-pressure,
// out-of-range access, reset mid-transaction and a 100-read streaming run.
module tb_mem_responder;

    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam int          LAT   = 3;
    localparam logic [31:0] EK    = 32'hE3E3_E3E3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic        req_w = 1'b0;
    logic        req_c = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        rsp_val;
    logic        rsp_rdy = 1'b0;
    logic [31:0] rsp_data;
    logic        addr_err;

    int n_cmp = 0;
    int n_err = 0;
    int last_waits = 0;

    mem_responder #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .RSP_LATENCY (LAT),
        .EMPTY_KEY   (EK)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .mem_req_val_i      (req_val),
        .mem_req_rdy_o      (req_rdy),
        .mem_req_is_write_i (req_w),
        .mem_req_is_cas_i   (req_c),
        .mem_req_addr_i     (req_addr),
        .mem_req_data_i     (req_data),
        .mem_rsp_val_o      (rsp_val),
        .mem_rsp_rdy_i      (rsp_rdy),
        .mem_rsp_data_o     (rsp_data),
        .addr_err_o         (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction; called right after an edge (or at a negedge). Holds the
    // response for 'hold' cycles before handshaking. Prints one line.
    task automatic txn(input logic w, input logic c, input logic [31:0] a,
                       input logic [31:0] d, input int hold, output logic [31:0] rsp);
        int waits;
        int lat;
        req_val = 1'b1; req_w = w; req_c = c; req_addr = a; req_data = d;
        waits = 0;
        while (!req_rdy && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        last_waits = waits;
        if (waits >= 200) begin
            check("accept_timeout", 32'd1, 32'd0);
            req_val = 1'b0;
            rsp = 'x;
            return;
        end
        @(posedge clk); #1;
        // scramble request fields: in-flight response must not change
        req_val = 1'b0; req_w = ~w; req_c = 1'b0; req_addr = ~a; req_data = ~d;
        lat = 1;
        while (!rsp_val && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(LAT));
        rsp = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_val", {31'd0, rsp_val}, 32'd1);
            check("hold_data", rsp_data, rsp);
            check("hold_req_rdy", {31'd0, req_rdy}, 32'd0);
        end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        check("post_hs_val", {31'd0, rsp_val}, 32'd0);
        check("post_hs_data", rsp_data, 32'd0);
`ifndef MEM_RESPONDER_STALL_EN
        check("post_hs_rdy", {31'd0, req_rdy}, 32'd1);
`endif
        $display("txn w=%0b cas=%0b addr=0x%08h data=0x%08h -> rsp=0x%08h lat=%0d err=%0b",
                 w, c, a, d, rsp, lat, addr_err);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] model [16];
        logic [31:0] exp_q [$];
        int any_val;
        int next_issue;
        int n_done;
        int stalls;
        logic prev_hs;
        logic acc;
        logic hs;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
`ifdef MEM_RESPONDER_STALL_EN
        check("reset_req_rdy", {31'd0, req_rdy}, 32'd0);
`else
        check("reset_req_rdy", {31'd0, req_rdy}, 32'd1);
`endif
        check("reset_rsp_val", {31'd0, rsp_val}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_addr_err", {31'd0, addr_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read, first acceptance on the first edge out of reset
        txn(1'b1, 1'b0, 32'h10, 32'h0000_DEAD, 0, r);
`ifndef MEM_RESPONDER_STALL_EN
        check("first_accept_waits", 32'(last_waits), 32'd0);
`endif
        check("write_rsp", r, 32'd0);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 0, r);
        check("read_rsp", r, 32'h0000_DEAD);
        txn(1'b0, 1'b0, 32'h13, 32'h0, 0, r);
        check("read_byte_offset", r, 32'h0000_DEAD);

        // CAS success on empty word, then fail on non-empty word
        txn(1'b0, 1'b1, 32'h20, 32'h0, 0, r);
        check("cas_empty_rsp", r, 32'd0);
        txn(1'b1, 1'b0, 32'h20, 32'd5, 0, r);
        check("preload_rsp", r, 32'd0);
        txn(1'b0, 1'b1, 32'h20, 32'h0, 0, r);
        check("cas_full_rsp", r, 32'd1);
        txn(1'b0, 1'b0, 32'h20, 32'h0, 0, r);
        check("cas_unchanged", r, 32'd5);
        txn(1'b1, 1'b1, 32'h44, 32'h77, 0, r);
        check("cas_overrides_write", r, 32'd0);
        txn(1'b0, 1'b0, 32'h44, 32'h0, 0, r);
        check("cas_stored", r, 32'h77);
        txn(1'b0, 1'b0, 32'h40, 32'h0, 0, r);
        check("unwritten_empty", r, EK);

        // Response held under back-pressure for 10 cycles
        txn(1'b0, 1'b0, 32'h10, 32'h0, 10, r);
        check("held_read_rsp", r, 32'h0000_DEAD);

        // Out-of-range accesses
        txn(1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 0, r);
        check("err_before_oor", {31'd0, addr_err}, 32'd0);
        txn(1'b0, 1'b0, 32'(DEPTH * 4), 32'h0, 0, r);
        check("oor_read_rsp", r, 32'd0);
        check("oor_err_set", {31'd0, addr_err}, 32'd1);
        txn(1'b1, 1'b0, 32'(DEPTH * 4), 32'h1234, 0, r);
        check("oor_write_rsp", r, 32'd0);
        txn(1'b0, 1'b0, 32'h0, 32'h0, 0, r);
        check("oor_no_alias", r, 32'h0BAD_F00D);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 0, r);
        check("oor_word4_intact", r, 32'h0000_DEAD);
        check("oor_err_held", {31'd0, addr_err}, 32'd1);

        // Reset one cycle after accepting a read of address 0
        req_val = 1'b1; req_w = 1'b0; req_c = 1'b0; req_addr = 32'h0;
        any_val = 0;
        while (!req_rdy && any_val < 200) begin
            @(negedge clk);
            any_val++;
        end
        @(posedge clk); #1;
        req_val = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_err_clear", {31'd0, addr_err}, 32'd0);
        check("midrst_val", {31'd0, rsp_val}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_rdy = 1'b1;
        any_val = 0;
        repeat (LAT + 4) begin
            @(posedge clk); #1;
            if (rsp_val) any_val++;
        end
        rsp_rdy = 1'b0;
        check("midrst_no_rsp", 32'(any_val), 32'd0);
        txn(1'b0, 1'b0, 32'h0, 32'h0, 0, r);
        check("midrst_addr0_empty", r, EK);

        // Preload 16 words for the streaming run
        for (int i = 0; i < 16; i++) begin
            model[i] = 32'hA000_0000 + 32'(i) * 32'h0101;
            txn(1'b1, 1'b0, 32'(i * 4), model[i], 0, r);
        end

        // 100 back-to-back reads with valid held high
        rsp_rdy = 1'b1;
        req_val = 1'b1; req_w = 1'b0; req_c = 1'b0; req_addr = 32'h0;
        next_issue = 0; n_done = 0; stalls = 0; prev_hs = 1'b0;
        for (int cyc = 0; cyc < 5000 && n_done < 100; cyc++) begin
            @(negedge clk);
            acc = req_rdy & req_val;
            hs  = rsp_val;
            if (prev_hs && !req_rdy) stalls++;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("b2b_order", 32'd1, 32'd0);
                end else begin
                    check("b2b_data", rsp_data, exp_q.pop_front());
                end
                n_done++;
                $display("b2b rsp %0d data=0x%08h", n_done, rsp_data);
            end
            if (acc) begin
                exp_q.push_back(model[next_issue % 16]);
                next_issue++;
            end
            prev_hs = hs;
            @(posedge clk); #1;
            if (acc) begin
                if (next_issue < 100) req_addr = 32'((next_issue % 16) * 4);
                else req_val = 1'b0;
            end
        end
        req_val = 1'b0;
        rsp_rdy = 1'b0;
        check("b2b_count", 32'(n_done), 32'd100);
`ifdef MEM_RESPONDER_STALL_EN
        check("b2b_stalled", {31'd0, (stalls > 0)}, 32'd1);
`else
        check("b2b_no_stall", 32'(stalls), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
